// File: rtl/muldiv_unit_if.sv
// Execute-stage <-> multiply/divide unit bus: operation request, HI/LO moves,
// flush, and the busy/done handshake the hazard unit stalls on.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply (shift-add) and divide (restoring) with
// architectural HI/LO registers; WIDTH+1 cycles from start to done.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  muldiv_unit_if.slave   bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               sgn_a;
  logic               sgn_b;
  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

  always_comb begin
    sgn_a    = ~bus.op[0] & bus.a[WIDTH-1];
    sgn_b    = ~bus.op[0] & bus.b[WIDTH-1];
    mag_a_in = sgn_a ? -bus.a : bus.a;
    mag_b_in = sgn_b ? -bus.b : bus.b;
  end

  // acc holds {partial product, multiplier} for mult and {remainder, dividend/quotient} for div
  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, mag_b};
    if (is_div) begin
      if (!trial[WIDTH]) acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else               acc_step = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod = neg_res ? -acc : acc;
    if (is_div) begin
      res_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      res_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      mag_b   <= '0;
      acc     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hi_we) hi_r <= bus.wdata;
          if (bus.lo_we) lo_r <= bus.wdata;
          if (bus.start && !bus.flush) begin
            state   <= CALC;
            busy_r  <= 1'b1;
            cnt     <= '0;
            acc     <= {{WIDTH{1'b0}}, mag_a_in};
            mag_b   <= mag_b_in;
            is_div  <= bus.op[1];
            // divide by zero keeps the all-ones quotient unsigned; the remainder still equals a
            neg_res <= (sgn_a ^ sgn_b) & ~(bus.op[1] & (bus.b == '0));
            neg_rem <= sgn_a & bus.op[1];
          end
        end
        CALC: begin
          if (bus.flush) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          if (!bus.flush) begin
            hi_r   <= res_hi;
            lo_r   <= res_lo;
            done_r <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. The ALU decoder flags mult/div through `alucontrol`, and the execute stage issues them here instead of computing them in the single-cycle ALU. The unit is generalised over operand width and supports signed and unsigned multiply and divide. It also provides direct HI/LO writes (mthi/mtlo), a pipeline-flush abort, and a busy/done handshake the hazard unit uses to stall.

## Interface
- `WIDTH`, 32, operand and HI/LO width; legal values ≥ 4.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request an operation; sampled only when `busy`=0.
- `op`  in  2  operation select: 00 = mult (signed), 01 = multu, 10 = div (signed), 11 = divu.
- `a`, `b`  in  WIDTH each  operands: multiplicand/multiplier, or dividend/divisor. Captured when a start is accepted.
- `flush`  in  1  abort the in-flight operation.
- `hi_we`, `lo_we`  in  1 each  mthi/mtlo write enables.
- `wdata`  in  WIDTH  data for `hi_we`/`lo_we`.
- `busy`  out  1  operation in flight; the hazard unit stalls on it.
- `done`  out  1  one-cycle pulse when a result has been committed.
- `hi`, `lo`  out  WIDTH each  architectural HI/LO registers.

## Operation
- FSM states: IDLE, CALC, FIX.
  - IDLE → CALC on `start`. On that edge the unit latches operand magnitudes, sign flags and `op`, and clears the iteration counter.
  - CALC runs exactly WIDTH iterations, counted by a $clog2(WIDTH+1)-bit counter, then goes to FIX.
  - FIX applies sign correction, writes HI/LO, sets `done`, and returns to IDLE.
- Multiply: radix-2 shift-add on magnitudes into a 2·WIDTH accumulator. The product is negated in FIX if the operand signs differ (signed op only). HI = upper WIDTH bits, LO = lower WIDTH bits.
- Divide: restoring division on magnitudes. LO = quotient, HI = remainder.
  - Signed op: the quotient is negated if the signs differ, and the remainder takes the sign of the dividend.
- Divide by zero (`b`=0, div or divu): LO = all ones, HI = `a` unchanged. The operation still takes the full latency.
- Signed overflow (most-negative value / −1): LO = most-negative value, HI = 0. This is the natural two's-complement wrap; no trap is raised.
- Unsigned ops treat `a` and `b` as magnitudes directly. The 2·WIDTH accumulator prevents any loss of product bits.
- `start` while `busy`=1 is ignored; operands are not re-latched.
- `hi_we`/`lo_we` while `busy`=1 are dropped.
  - In IDLE they write `wdata` at the next edge.
  - If `start` and `hi_we` arrive together in IDLE, the write lands first and the later result overwrites it.
- `flush` in CALC or FIX returns the FSM to IDLE at the next edge. HI/LO are left unchanged and no `done` is produced.
  - `flush` in IDLE has no effect.
  - `flush` together with `start` in IDLE drops the start.
- Reset at any time aborts immediately. All outputs reset to 0 and the FSM goes to IDLE.

## Timing
- Start accepted at edge E0.
- `busy`=1 from just after E0 until edge E(WIDTH+1).
- CALC occupies edges E1..E(WIDTH). FIX commits at edge E(WIDTH+1).
- After E(WIDTH+1): `done`=1 for one cycle, `hi`/`lo` show the new values, and `busy`=0.
  - A new `start` may be accepted in that same cycle.
- Start-to-done latency is WIDTH+1 edges, i.e. 33 for WIDTH=32.
- `busy`, `done`, `hi` and `lo` are all registered outputs, with no combinational path from the inputs.
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0.

## Test plan
- mult, `a`=0xFFFFFFFD (−3), `b`=7, WIDTH=32 → `done` exactly 33 edges after the start edge; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `busy` high for exactly 33 cycles.
- multu, `a`=`b`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- div, `a`=0xFFFFFFF9 (−7), `b`=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then div 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- divu, `a`=5, `b`=0 → `lo`=0xFFFFFFFF, `hi`=0x00000005, with full latency.
- Preload `hi`=0x1234 via `hi_we`. Start mult, then assert `flush` 10 cycles later → `busy` falls at the next edge, no `done`, `hi` stays 0x1234. `start` pulses and `hi_we` while busy have no effect.
- Assert `reset` low mid-CALC → `busy`, `done`, `hi`, `lo` go to 0 immediately. After release, a fresh multu 3×5 gives `lo`=15, `hi`=0.
